// File: rtl/nonce_seq_pkg.sv
// Shared types and defaults for the nonce sequencer: FSM states, word
// select encodings and default sizing constants.
package nonce_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_ARMED,
    S_EMIT_LO,
    S_EMIT_HI,
    S_WAIT_HASH,
    S_INC
  } state_e;

  localparam logic WORD_LO = 1'b0;
  localparam logic WORD_HI = 1'b1;

  localparam int NONCE_BYTES_DEF    = 12;
  localparam int COUNT_W_DEF        = 32;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  // Parked states are the only ones where the sequencer is not working.
  function automatic logic is_busy(state_e s);
    return !(s == S_IDLE || s == S_ARMED);
  endfunction

endpackage

// File: rtl/nonce_load_counter.sv
// Counts UART bytes accepted during a nonce load; last_o flags that the
// next accepted byte completes the nonce.
module nonce_load_counter
  import nonce_seq_pkg::*;
#(
  parameter int NONCE_BYTES = NONCE_BYTES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int CW = $clog2(NONCE_BYTES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == CW'(NONCE_BYTES - 1));

endmodule

// File: rtl/nonce_sequencer.sv
// Sequences nonce_module: UART load, arm, low/high word emission to the
// hasher, increment and repeat. Optional hash watchdog: NONCE_SEQ_TIMEOUT_EN.
module nonce_sequencer
  import nonce_seq_pkg::*;
#(
  parameter int NONCE_BYTES    = NONCE_BYTES_DEF,
  parameter int COUNT_W        = COUNT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rx_valid_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               word_ready_i,
  input  logic               hash_done_i,
  output logic               shift_in_o,
  output logic               ready_o,
  output logic               increment_o,
  output logic               nonce_address_o,
  output logic               output_enable_o,
  output logic               word_valid_o,
  output logic               word_last_o,
  output logic               busy_o,
  output logic [COUNT_W-1:0] nonce_count_o,
  output logic               timeout_o
);

  state_e state_q, state_d;
  logic   load_last;
  logic   shift_in;
  logic   wd_expired;
  logic   timeout_hit;
  logic   stop_pending_q;

  logic               ready_q, inc_q, addr_q, oe_q, valid_q, last_q, busy_q;
  logic [COUNT_W-1:0] count_q;

  nonce_load_counter #(
    .NONCE_BYTES (NONCE_BYTES)
  ) u_load_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_q == S_ARM),
    .en_i   (shift_in),
    .last_o (load_last)
  );

  always_comb begin
    state_d     = state_q;
    shift_in    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE, S_ARMED: begin
        // A new byte always wins over start: the host is reloading.
        if (rx_valid_i) begin
          shift_in = 1'b1;
          state_d  = load_last ? S_ARM : S_LOAD;
        end else if (state_q == S_ARMED && start_i) begin
          state_d = S_EMIT_LO;
        end
      end
      S_LOAD: begin
        if (rx_valid_i) begin
          shift_in = 1'b1;
          if (load_last) state_d = S_ARM;
        end
      end
      S_ARM:       state_d = S_ARMED;
      S_EMIT_LO:   if (word_ready_i) state_d = S_EMIT_HI;
      S_EMIT_HI:   if (word_ready_i) state_d = S_WAIT_HASH;
      S_WAIT_HASH: begin
        if (hash_done_i) begin
          state_d = S_INC;
        end else if (wd_expired) begin
          state_d     = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_INC:   state_d = (stop_pending_q || stop_i) ? S_ARMED : S_EMIT_LO;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      stop_pending_q <= 1'b0;
      ready_q        <= 1'b0;
      inc_q          <= 1'b0;
      addr_q         <= WORD_LO;
      oe_q           <= 1'b0;
      valid_q        <= 1'b0;
      last_q         <= 1'b0;
      busy_q         <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_ARM);
      inc_q   <= (state_d == S_INC);
      addr_q  <= (state_d == S_EMIT_HI) ? WORD_HI : WORD_LO;
      oe_q    <= (state_d inside {S_EMIT_LO, S_EMIT_HI});
      valid_q <= (state_d inside {S_EMIT_LO, S_EMIT_HI});
      last_q  <= (state_d == S_EMIT_HI);
      busy_q  <= is_busy(state_d);

      if (state_d == S_ARM)      count_q <= '0;
      else if (state_d == S_INC) count_q <= count_q + 1'b1;

      // A stop is consumed once the sequencer parks, so a later start runs freely.
      if (state_q == S_ARM || (state_q == S_INC && state_d == S_ARMED))
        stop_pending_q <= 1'b0;
      else if (stop_i && (state_q inside {S_EMIT_LO, S_EMIT_HI, S_WAIT_HASH, S_INC}))
        stop_pending_q <= 1'b1;
    end
  end

`ifdef NONCE_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= (state_q == S_WAIT_HASH && state_d == S_WAIT_HASH) ? wd_q + 1'b1 : '0;
      if (state_d == S_ARM)  timeout_q <= 1'b0;
      else if (timeout_hit)  timeout_q <= 1'b1;
    end
  end

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o  = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_hit | (TIMEOUT_CYCLES == 0);
  assign wd_expired     = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  assign shift_in_o      = shift_in & ~rst_i;
  assign ready_o         = ready_q;
  assign increment_o     = inc_q;
  assign nonce_address_o = addr_q;
  assign output_enable_o = oe_q;
  assign word_valid_o    = valid_q;
  assign word_last_o     = last_q;
  assign busy_o          = busy_q;
  assign nonce_count_o   = count_q;

endmodule

// File: tb/tb_nonce_sequencer.sv
// Randomized bench for nonce_sequencer: phase-level expectations with a
// scoreboarded nonce count (COUNT_W=4 to exercise wrap).
module tb_nonce_sequencer;

  localparam int NB = 12;
  localparam int CW = 4;
  localparam int TO = 8;

  // {ready, increment, addr, oe, valid, last, busy} expected per phase
  localparam logic [6:0] O_PARK = 7'b0000000;
  localparam logic [6:0] O_LOAD = 7'b0000001;
  localparam logic [6:0] O_ARM  = 7'b1000001;
  localparam logic [6:0] O_LO   = 7'b0001101;
  localparam logic [6:0] O_HI   = 7'b0011111;
  localparam logic [6:0] O_WAIT = 7'b0000001;
  localparam logic [6:0] O_INC  = 7'b0100001;

  logic clk = 1'b0;
  logic rst_i, rx_valid_i, start_i, stop_i, word_ready_i, hash_done_i;
  logic shift_in_o, ready_o, increment_o, nonce_address_o, output_enable_o;
  logic word_valid_o, word_last_o, busy_o, timeout_o;
  logic [CW-1:0] nonce_count_o;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  nonce_sequencer #(.NONCE_BYTES(NB), .COUNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_valid_i(rx_valid_i), .start_i(start_i),
    .stop_i(stop_i), .word_ready_i(word_ready_i), .hash_done_i(hash_done_i),
    .shift_in_o(shift_in_o), .ready_o(ready_o), .increment_o(increment_o),
    .nonce_address_o(nonce_address_o), .output_enable_o(output_enable_o),
    .word_valid_o(word_valid_o), .word_last_o(word_last_o), .busy_o(busy_o),
    .nonce_count_o(nonce_count_o), .timeout_o(timeout_o)
  );

  function automatic logic [6:0] outs();
    return {ready_o, increment_o, nonce_address_o, output_enable_o,
            word_valid_o, word_last_o, busy_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_in();
    rx_valid_i = 0; start_i = 0; stop_i = 0; word_ready_i = 0; hash_done_i = 0;
  endtask

  // Enter at a negedge in IDLE/ARMED with inputs idle; leaves at a negedge in ARMED.
  task automatic load_nonce(input bit with_start, input int gap);
    int g;
    for (int b = 0; b < NB; b++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int i = 0; i < g; i++) begin
        rx_valid_i  = 0;
        start_i     = (b > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        stop_i      = 1'($urandom_range(0, 1));
        hash_done_i = 1'($urandom_range(0, 1));
        #1 chk("shift_gap", shift_in_o, 0);
        tick();
        chk("load_gap_outs", outs(), (b == 0) ? O_PARK : O_LOAD);
      end
      rx_valid_i  = 1;
      start_i     = (b == 0) ? with_start : 1'($urandom_range(0, 1));
      stop_i      = 1'($urandom_range(0, 1));
      hash_done_i = 1'($urandom_range(0, 1));
      #1 chk("shift_byte", shift_in_o, 1);
      tick();
      if (b < NB - 1) chk("load_outs", outs(), O_LOAD);
    end
    idle_in();
    chk("arm_outs", outs(), O_ARM);
    chk("arm_count", nonce_count_o, 0);
    exp_count = 0;
    tick();
    chk("armed_outs", outs(), O_PARK);
  endtask

  // Start from ARMED, run n nonces, stop during phase ph of the last one.
  task automatic run_nonces(input int n, input int ph, input int lo_first, input int lat_fixed);
    int ls, hs, lat;
    bit stp;
    start_i = 1; tick(); start_i = 0;
    for (int k = 1; k <= n; k++) begin
      ls  = (k == 1 && lo_first >= 0) ? lo_first : int'($urandom_range(0, 2));
      hs  = $urandom_range(0, 2);
      lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
      stp = (k == n);
      for (int s = 0; s <= ls; s++) begin
        chk("lo_outs", outs(), O_LO);
        chk("lo_count", nonce_count_o, exp_count);
        word_ready_i = (s == ls);
        stop_i       = stp && ph == 0 && s == 0;
        hash_done_i  = 1'($urandom_range(0, 1));
        tick();
      end
      for (int s = 0; s <= hs; s++) begin
        chk("hi_outs", outs(), O_HI);
        word_ready_i = (s == hs);
        stop_i       = stp && ph == 1 && s == 0;
        hash_done_i  = 1'($urandom_range(0, 1));
        tick();
      end
      for (int s = 0; s < lat; s++) begin
        chk("wait_outs", outs(), O_WAIT);
        word_ready_i = 1'($urandom_range(0, 1));
        stop_i       = stp && ph == 2 && s == 0;
        hash_done_i  = (s == lat - 1);
        tick();
      end
      exp_count = (exp_count + 1) % (1 << CW);
      chk("inc_outs", outs(), O_INC);
      chk("inc_count", nonce_count_o, exp_count);
      chk("inc_timeout", timeout_o, 0);
      idle_in();
      stop_i = stp && ph == 3;
      tick();
      stop_i = 0;
    end
    for (int i = 0; i < 3; i++) begin
      chk("stopped_outs", outs(), O_PARK);
      chk("stopped_count", nonce_count_o, exp_count);
      word_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    idle_in();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    idle_in();
    rst_i = 1;
    repeat (3) tick();
    chk("reset_outs", outs(), O_PARK);
    chk("reset_count", nonce_count_o, 0);
    chk("reset_timeout", timeout_o, 0);
    rx_valid_i = 1;
    #1 chk("reset_shift", shift_in_o, 0);
    tick();
    rst_i = 0; rx_valid_i = 0;

    start_i = 1; tick(); start_i = 0;
    chk("idle_start_ignored", outs(), O_PARK);

    // Paced load, then 3 nonces with LO backpressure and stop in EMIT_HI.
    load_nonce(1'b0, 3);
    run_nonces(3, 1, 4, 5);
    // Reload with start in the same cycle, then wrap the 4-bit counter.
    load_nonce(1'b1, -1);
    run_nonces(16, int'($urandom_range(0, 3)), -1, 0);
    for (int r = 0; r < 4; r++) begin
      load_nonce(1'($urandom_range(0, 1)), -1);
      run_nonces(int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), -1, 0);
    end

    // Reset while waiting for the hash aborts everything.
    load_nonce(1'b0, -1);
    start_i = 1; tick(); start_i = 0;
    word_ready_i = 1; tick(); tick(); word_ready_i = 0;
    chk("pre_reset_wait", outs(), O_WAIT);
    rst_i = 1; tick(); rst_i = 0;
    chk("abort_outs", outs(), O_PARK);
    chk("abort_count", nonce_count_o, 0);
    hash_done_i = 1; tick(); hash_done_i = 0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_hash_ignored", outs(), O_PARK);
      tick();
    end

`ifdef NONCE_SEQ_TIMEOUT_EN
    load_nonce(1'b0, -1);
    start_i = 1; tick(); start_i = 0;
    word_ready_i = 1; tick(); tick(); word_ready_i = 0;
    for (int i = 0; i < TO; i++) begin
      chk("to_wait_outs", outs(), O_WAIT);
      chk("to_not_yet", timeout_o, 0);
      tick();
    end
    chk("to_idle_outs", outs(), O_PARK);
    chk("to_flag", timeout_o, 1);
    chk("to_count", nonce_count_o, 0);
    tick();
    chk("to_sticky", timeout_o, 1);
    load_nonce(1'b0, -1);
    chk("to_cleared_by_arm", timeout_o, 0);
`else
    chk("timeout_tied", timeout_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
